cam_access_ctrl: RTL and testbench



---
 rtl/cam_access_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_cam_access_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_access_ctrl.sv
// cam_access_ctrl: schedules one update requester and one lookup requester onto a shared CAM.
// An update writes the new key over the old one for WRITE_CYCLES cycles. It then waits for the
// CAM to drop busy, and a sticky error is raised if busy stays high for BUSY_TIMEOUT cycles.
// A lookup drives the key, samples the match SEARCH_LATENCY cycles later and stores it in a
// one-entry result register that supports backpressure.
// Optional macro CAM_CTRL_STATS_EN adds saturating 16-bit lookup/hit/update counters.
module cam_access_ctrl #(
    parameter int DATA_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 2,
    parameter int WRITE_CYCLES   = 2,
    parameter int SEARCH_LATENCY = 1,
    parameter int MAX_WR_BURST   = 4,
    parameter int BUSY_TIMEOUT   = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_upd_valid,
    output logic                  o_upd_ready,
    input  logic [ADDR_WIDTH-1:0] i_upd_addr,
    input  logic [DATA_WIDTH-1:0] i_upd_key,
    input  logic [DATA_WIDTH-1:0] i_upd_old_key,
    input  logic                  i_srch_valid,
    output logic                  o_srch_ready,
    input  logic [DATA_WIDTH-1:0] i_srch_key,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic                  o_res_match,
    output logic [ADDR_WIDTH-1:0] o_res_addr,
    output logic                  o_err_timeout,
`ifdef CAM_CTRL_STATS_EN
    output logic [15:0]           o_stat_lookups,
    output logic [15:0]           o_stat_hits,
    output logic [15:0]           o_stat_updates,
`endif
    output logic                  o_cam_write_enable,
    output logic [DATA_WIDTH-1:0] o_cam_din,
    output logic [DATA_WIDTH-1:0] o_cam_cmp_din,
    output logic [ADDR_WIDTH-1:0] o_cam_write_addr,
    input  logic                  i_cam_busy,
    input  logic                  i_cam_match,
    input  logic [ADDR_WIDTH-1:0] i_cam_match_addr
);

    localparam int CYC_MAX = (WRITE_CYCLES > SEARCH_LATENCY) ? WRITE_CYCLES : SEARCH_LATENCY;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int BURST_W = $clog2(MAX_WR_BURST + 1);
    localparam int TMO_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_ISSUE = 3'd1;
    localparam logic [2:0] S_WR_WAIT  = 3'd2;
    localparam logic [2:0] S_SR_ISSUE = 3'd3;
    localparam logic [2:0] S_SR_WAIT  = 3'd4;

    logic [2:0]            r_state, w_state_nxt;
    logic [CYC_W-1:0]      r_cyc, w_cyc_nxt;
    logic [TMO_W-1:0]      r_tmo, w_tmo_nxt;
    logic [BURST_W-1:0]    r_burst, w_burst_nxt;
    logic                  r_err, w_err_nxt;
    logic [DATA_WIDTH-1:0] r_cam_din, w_cam_din_nxt;
    logic [DATA_WIDTH-1:0] r_cam_cmp, w_cam_cmp_nxt;
    logic [ADDR_WIDTH-1:0] r_cam_waddr, w_cam_waddr_nxt;
    logic                  r_res_valid, w_res_valid_nxt;
    logic                  r_res_match, w_res_match_nxt;
    logic [ADDR_WIDTH-1:0] r_res_addr, w_res_addr_nxt;

    logic w_idle, w_upd_base, w_srch_base, w_srch_wins;
    logic w_upd_rdy, w_srch_rdy, w_upd_go, w_srch_go, w_sample;

    // Requests are never accepted while reset is asserted, so readies read 0 then.
    assign w_idle      = (r_state == S_IDLE);
    assign w_upd_base  = w_idle & ~i_cam_busy & ~r_err & ~i_rst;
    assign w_srch_base = w_upd_base & ~(r_res_valid & ~i_res_ready);
    // A waiting lookup is forced in once MAX_WR_BURST updates have jumped ahead of it.
    assign w_srch_wins = w_srch_base & i_srch_valid & (r_burst == BURST_W'(MAX_WR_BURST));
    assign w_upd_rdy   = w_upd_base & ~w_srch_wins;
    assign w_srch_rdy  = w_srch_base & ~(i_upd_valid & w_upd_rdy);
    assign w_upd_go    = i_upd_valid & w_upd_rdy;
    assign w_srch_go   = i_srch_valid & w_srch_rdy;

    // The match is sampled in SR_ISSUE for zero latency, otherwise in the last SR_WAIT cycle.
    assign w_sample = ((r_state == S_SR_ISSUE) && (SEARCH_LATENCY == 0)) ||
                      ((r_state == S_SR_WAIT) && (r_cyc == CYC_W'(SEARCH_LATENCY - 1)));

    assign o_upd_ready        = w_upd_rdy;
    assign o_srch_ready       = w_srch_rdy;
    assign o_res_valid        = r_res_valid;
    assign o_res_match        = r_res_match;
    assign o_res_addr         = r_res_addr;
    assign o_err_timeout      = r_err;
    assign o_cam_write_enable = (r_state == S_WR_ISSUE);
    assign o_cam_din          = r_cam_din;
    assign o_cam_cmp_din      = r_cam_cmp;
    assign o_cam_write_addr   = r_cam_waddr;

    // Next-state logic for the sequencer, the arbitration counter and the result register.
    always_comb begin
        w_state_nxt     = r_state;
        w_cyc_nxt       = r_cyc;
        w_tmo_nxt       = r_tmo;
        w_err_nxt       = r_err;
        w_cam_din_nxt   = r_cam_din;
        w_cam_cmp_nxt   = r_cam_cmp;
        w_cam_waddr_nxt = r_cam_waddr;
        w_burst_nxt     = r_burst;
        w_res_valid_nxt = r_res_valid;
        w_res_match_nxt = r_res_match;
        w_res_addr_nxt  = r_res_addr;

        case (r_state)
            S_IDLE: begin
                if (w_upd_go) begin
                    w_state_nxt     = S_WR_ISSUE;
                    w_cyc_nxt       = '0;
                    w_cam_din_nxt   = i_upd_key;
                    w_cam_cmp_nxt   = i_upd_old_key;
                    w_cam_waddr_nxt = i_upd_addr;
                end else if (w_srch_go) begin
                    w_state_nxt   = S_SR_ISSUE;
                    w_cyc_nxt     = '0;
                    w_cam_din_nxt = i_srch_key;
                end
            end
            S_WR_ISSUE: begin
                if (r_cyc == CYC_W'(WRITE_CYCLES - 1)) begin
                    w_state_nxt = S_WR_WAIT;
                    w_tmo_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            S_WR_WAIT: begin
                if (!i_cam_busy) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tmo == TMO_W'(BUSY_TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_SR_ISSUE: begin
                w_cyc_nxt   = '0;
                w_state_nxt = (SEARCH_LATENCY == 0) ? S_IDLE : S_SR_WAIT;
            end
            S_SR_WAIT: begin
                if (w_sample) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Saturating at MAX_WR_BURST keeps the equality test valid while a result blocks lookups.
        if (!i_srch_valid || w_srch_go) begin
            w_burst_nxt = '0;
        end else if (w_upd_go && (r_burst != BURST_W'(MAX_WR_BURST))) begin
            w_burst_nxt = r_burst + BURST_W'(1);
        end

        if (w_sample) begin
            w_res_valid_nxt = 1'b1;
            w_res_match_nxt = i_cam_match;
            w_res_addr_nxt  = i_cam_match ? i_cam_match_addr : '0;
        end else if (r_res_valid && i_res_ready) begin
            w_res_valid_nxt = 1'b0;
        end
    end

    // State registers with synchronous reset; reset aborts any write or search in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_tmo       <= '0;
            r_err       <= 1'b0;
            r_cam_din   <= '0;
            r_cam_cmp   <= '0;
            r_cam_waddr <= '0;
            r_burst     <= '0;
            r_res_valid <= 1'b0;
            r_res_match <= 1'b0;
            r_res_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cyc       <= w_cyc_nxt;
            r_tmo       <= w_tmo_nxt;
            r_err       <= w_err_nxt;
            r_cam_din   <= w_cam_din_nxt;
            r_cam_cmp   <= w_cam_cmp_nxt;
            r_cam_waddr <= w_cam_waddr_nxt;
            r_burst     <= w_burst_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_match <= w_res_match_nxt;
            r_res_addr  <= w_res_addr_nxt;
        end
    end

`ifdef CAM_CTRL_STATS_EN
    logic [15:0] r_stat_lookups, r_stat_hits, r_stat_updates;

    assign o_stat_lookups = r_stat_lookups;
    assign o_stat_hits    = r_stat_hits;
    assign o_stat_updates = r_stat_updates;

    // Saturating event counters for lookups accepted, hits loaded and updates accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
            r_stat_updates <= '0;
        end else begin
            if (w_srch_go && (r_stat_lookups != 16'hFFFF)) begin
                r_stat_lookups <= r_stat_lookups + 16'd1;
            end
            if (w_sample && i_cam_match && (r_stat_hits != 16'hFFFF)) begin
                r_stat_hits <= r_stat_hits + 16'd1;
            end
            if (w_upd_go && (r_stat_updates != 16'hFFFF)) begin
                r_stat_updates <= r_stat_updates + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Directed bench for cam_access_ctrl with a behavioural CAM and a result scoreboard.
module tb_cam_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic [1:0] upd_addr = '0;
    logic [3:0] upd_key = '0;
    logic [3:0] upd_old_key = '0;
    logic       srch_valid = 1'b0;
    logic       srch_ready;
    logic [3:0] srch_key = '0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic       res_match;
    logic [1:0] res_addr;
    logic       err_timeout;
    logic       cam_we;
    logic [3:0] cam_din;
    logic [3:0] cam_cmp;
    logic [1:0] cam_wa;
    logic       cam_busy = 1'b0;
    logic       cam_match;
    logic [1:0] cam_match_addr;

    typedef struct packed {
        logic       match;
        logic [1:0] addr;
    } res_t;

    res_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         we_cnt = 0;
    int         we_bad = 0;
    logic [1:0] exp_wa = '0;
    logic [3:0] exp_key = '0;
    logic [3:0] exp_old = '0;
    string      grants = "";
    logic       last_upd = 1'b0;
    logic       last_srch = 1'b0;

    // Behavioural CAM: one-cycle search latency, lowest matching address wins.
    logic [3:0] cam_mem [4] = '{default: 4'h0};
    logic [3:0] cam_v = '0;
    logic       m_hit = 1'b0;
    logic [1:0] m_addr = '0;
    // Reference contents as seen by the requesters.
    logic [3:0] ref_key [4] = '{default: 4'h0};
    logic [3:0] ref_v = '0;

    assign cam_match      = m_hit;
    assign cam_match_addr = m_addr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cam_we) begin
            cam_mem[cam_wa] <= cam_din;
            cam_v[cam_wa]   <= 1'b1;
        end
        m_hit  <= 1'b0;
        m_addr <= '0;
        for (int i = 3; i >= 0; i--) begin
            if (cam_v[i] && cam_mem[i] == cam_din) begin
                m_hit  <= 1'b1;
                m_addr <= 2'(i);
            end
        end
    end

    cam_access_ctrl dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_upd_valid        (upd_valid),
        .o_upd_ready        (upd_ready),
        .i_upd_addr         (upd_addr),
        .i_upd_key          (upd_key),
        .i_upd_old_key      (upd_old_key),
        .i_srch_valid       (srch_valid),
        .o_srch_ready       (srch_ready),
        .i_srch_key         (srch_key),
        .o_res_valid        (res_valid),
        .i_res_ready        (res_ready),
        .o_res_match        (res_match),
        .o_res_addr         (res_addr),
        .o_err_timeout      (err_timeout),
        .o_cam_write_enable (cam_we),
        .o_cam_din          (cam_din),
        .o_cam_cmp_din      (cam_cmp),
        .o_cam_write_addr   (cam_wa),
        .i_cam_busy         (cam_busy),
        .i_cam_match        (cam_match),
        .i_cam_match_addr   (cam_match_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t lookup_ref(input logic [3:0] k);
        res_t r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (ref_v[i] && ref_key[i] == k) begin
                r.match = 1'b1;
                r.addr  = 2'(i);
            end
        end
        return r;
    endfunction

    // Observes the handshakes the coming edge will take, then advances one cycle.
    task automatic step();
        res_t e;
        #1;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check("res_match", res_match, e.match);
                check("res_addr", res_addr, e.addr);
            end
        end
        if (srch_valid && srch_ready) begin
            exp_q.push_back(lookup_ref(srch_key));
            grants    = {grants, "S"};
            last_srch = 1'b1;
        end
        if (upd_valid && upd_ready) begin
            ref_key[upd_addr] = upd_key;
            ref_v[upd_addr]   = 1'b1;
            exp_wa   = upd_addr;
            exp_key  = upd_key;
            exp_old  = upd_old_key;
            grants   = {grants, "U"};
            last_upd = 1'b1;
        end
        if (cam_we) begin
            we_cnt++;
            if (cam_wa !== exp_wa || cam_din !== exp_key || cam_cmp !== exp_old) we_bad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        check(tag, res_valid, 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            step();
            n++;
        end
        check(tag, 32'(exp_q.size()), 0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_upd_ready", upd_ready, 0);
        check("rst_srch_ready", srch_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_err", err_timeout, 0);
        check("rst_we", cam_we, 0);
        check("rst_cam_din", cam_din, 0);
        rst = 1'b0;
        #1;
        check("idle_upd_ready", upd_ready, 1);
        check("idle_srch_ready", srch_ready, 1);

        // Lookup on an empty CAM: result two cycles after accept, miss
        srch_valid = 1'b1;
        srch_key   = 4'hA;
        step();
        srch_valid = 1'b0;
        step();
        check("lat_not_yet", res_valid, 0);
        step();
        check("lat_valid", res_valid, 1);
        drain("drain_miss");

        // Update addr 2 with key 5: write enable held exactly two cycles
        we_cnt      = 0;
        we_bad      = 0;
        upd_valid   = 1'b1;
        upd_addr    = 2'd2;
        upd_key     = 4'h5;
        upd_old_key = 4'h0;
        step();
        upd_valid = 1'b0;
        repeat (6) step();
        check("we_cycles", 32'(we_cnt), 2);
        check("we_fields", 32'(we_bad), 0);

        // Lookup of the key just written hits at addr 2
        srch_valid = 1'b1;
        srch_key   = 4'h5;
        step();
        srch_valid = 1'b0;
        drain("drain_hit");

        // Both requesters always valid: four updates then one lookup, repeating
        grants     = "";
        upd_valid  = 1'b1;
        srch_valid = 1'b1;
        for (int n = 0; n < 300 && grants.len() < 15; n++) begin
            last_upd  = 1'b0;
            last_srch = 1'b0;
            step();
            if (last_upd) begin
                upd_addr    = 2'($urandom);
                upd_old_key = 4'($urandom);
                upd_key     = 4'($urandom);
            end
            if (last_srch) srch_key = 4'($urandom);
        end
        upd_valid  = 1'b0;
        srch_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("grant%0d", i), 32'(grants[i]), (i % 5 == 4) ? 32'h53 : 32'h55);
        end
        drain("drain_burst");

        // Backpressure: pending result blocks further lookups and stays stable
        res_ready  = 1'b0;
        srch_valid = 1'b1;
        srch_key   = 4'h5;
        step();
        srch_valid = 1'b0;
        wait_res("bp_res_valid");
        srch_valid = 1'b1;
        srch_key   = 4'h3;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_srch_ready", srch_ready, 0);
            check("bp_res_match", res_match, exp_q[0].match);
            check("bp_res_addr", res_addr, exp_q[0].addr);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_srch_ready", srch_ready, 1);
        step();
        srch_valid = 1'b0;
        drain("drain_bp");

        // Busy stuck high after an update: sticky timeout after 64 WR_WAIT cycles
        upd_valid   = 1'b1;
        upd_addr    = 2'd3;
        upd_key     = 4'h9;
        upd_old_key = 4'h0;
        step();
        upd_valid = 1'b0;
        cam_busy  = 1'b1;
        repeat (65) step();
        check("tmo_not_yet", err_timeout, 0);
        step();
        check("tmo_err", err_timeout, 1);
        upd_valid  = 1'b1;
        srch_valid = 1'b1;
        for (int i = 0; i < 34; i++) begin
            if (i == 20) cam_busy = 1'b0;
            #1;
            if (i % 10 == 9) begin
                check("tmo_upd_ready", upd_ready, 0);
                check("tmo_srch_ready", srch_ready, 0);
                check("tmo_sticky", err_timeout, 1);
            end
            step();
        end
        upd_valid  = 1'b0;
        srch_valid = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("tmo_cleared", err_timeout, 0);
        check("tmo_rst_upd_ready", upd_ready, 1);

        // Reset during WR_ISSUE with a result pending
        res_ready  = 1'b0;
        srch_valid = 1'b1;
        srch_key   = 4'h9;
        step();
        srch_valid = 1'b0;
        wait_res("ab_res_valid");
        upd_valid   = 1'b1;
        upd_addr    = 2'd1;
        upd_key     = 4'h7;
        upd_old_key = 4'h0;
        step();
        upd_valid = 1'b0;
        check("ab_we_issue", cam_we, 1);
        rst = 1'b1;
        step();
        check("ab_we", cam_we, 0);
        check("ab_res_valid", res_valid, 0);
        check("ab_err", err_timeout, 0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("ab_idle_upd_ready", upd_ready, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
